// File: rtl/rca_load_ou_pkg.sv
// Shared types and constants for the RCA load operation unit: datapath width,
// LSQ load-type encodings and the result FIFO entry layout.
package rca_load_ou_pkg;

    localparam int XLEN = 32;
    localparam int RCA_LOAD_OU_DEPTH = 4;

    // LSQ load-type encodings (funct3 of the RISC-V load instructions)
    localparam logic [2:0] LS_B_fn3  = 3'b000;
    localparam logic [2:0] LS_H_fn3  = 3'b001;
    localparam logic [2:0] LS_W_fn3  = 3'b010;
    localparam logic [2:0] LS_BU_fn3 = 3'b100;
    localparam logic [2:0] LS_HU_fn3 = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0] data;
    } load_ou_fifo_entry_t;

endpackage

// File: rtl/rca_ou_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate flag.
module rca_ou_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; stale entries are never visible while empty matters.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rca_load_ou.sv
// Pipelined load operation unit: issues loads to the LSQ under a credit limit
// shared between in-flight loads and buffered results, returned in order.
module rca_load_ou
    import rca_load_ou_pkg::*;
#(
    parameter logic [2:0]             FN3         = LS_W_fn3,
    parameter logic signed [XLEN-1:0] ADDR_OFFSET = '0,
    parameter int                     DEPTH       = RCA_LOAD_OU_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] data_in1,
    input  logic [XLEN-1:0] data_in2,
    input  logic            data_valid_in1,
    input  logic            data_valid_in2,
    output logic            data_in_ack1,
    output logic            data_in_ack2,
    output logic            uses_data_in1,
    output logic            uses_data_in2,
    output logic [XLEN-1:0] data_out,
    output logic            data_valid_out,
    input  logic            data_out_ack,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] data,
    output logic [2:0]      fn3,
    output logic            load,
    output logic            store,
    output logic            new_request,
    input  logic            lsq_full,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_complete
);

    localparam int         CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         credits_used;
    logic                issue;
    logic                complete;
    logic                pop;
    logic                fifo_empty;
    logic                fifo_full;
    load_ou_fifo_entry_t push_entry;
    load_ou_fifo_entry_t head_entry;
    logic                unused_inputs;

    assign unused_inputs = ^{data_in2, data_valid_in2};

    assign data_in_ack2  = 1'b0;
    assign uses_data_in1 = 1'b1;
    assign uses_data_in2 = 1'b0;
    assign data          = '0;
    assign fn3           = FN3;
    assign load          = 1'b1;
    assign store         = 1'b0;
    assign addr          = data_in1 + ADDR_OFFSET;

    // Credits come from registered counts only: a pop frees its slot next cycle.
    assign credits_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign issue        = data_valid_in1 && !lsq_full && (credits_used < CREDITS) && !rst;
    assign new_request  = issue;
    assign data_in_ack1 = issue;

    assign complete = load_complete && (outstanding != '0);
    assign pop      = data_valid_out && data_out_ack;

    always_ff @(posedge clk) begin
        if (rst) outstanding <= '0;
        else     outstanding <= outstanding + CW'(issue) - CW'(complete);
    end

    assign push_entry.data = load_data;

    rca_ou_fifo #(
        .WIDTH ($bits(load_ou_fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (complete),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign data_out       = head_entry.data;
    assign data_valid_out = !fifo_empty;

`ifndef SYNTHESIS
    a_credit_limit: assert property (@(posedge clk) disable iff (rst) credits_used <= CREDITS);
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(complete && fifo_full));
    c_spurious:     cover property (@(posedge clk) disable iff (rst) load_complete && outstanding == '0);
`endif

endmodule
